// File: rtl/serial_mod_checker.sv
// serial_mod_checker: running remainder modulo MOD of a serial bit stream.
//
// Each accepted bit (in_valid high) extends the value of the current frame and
// the block keeps that value modulo MOD, reporting divisibility one cycle later.
// Only shifts, adds and a single conditional subtract are used; there is no
// divider or multiplier.
//
// Parameters:
//   modulus         - 2..255 (elaboration error otherwise)
//   counter width   - width of the saturating per-frame bit counter
//   remainder width - derived as $clog2 of the modulus
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset, overrides all other inputs
//   in_valid    in   in_bit is accepted this cycle
//   in_bit      in   serial data bit
//   frame_start in   begin a new value (with in_valid: this bit is the first)
//   lsb_first   in   only with SMC_LSB_MODE_EN: accepted bit is LSB-first
//   out_valid   out  one-cycle pulse after each accepted bit
//   remainder   out  running value mod MOD
//   divisible   out  remainder == 0
//   bit_count   out  bits accepted in the current frame, saturating
//   busy        out  a frame is open
//
// Optional feature: define SMC_LSB_MODE_EN to add the lsb_first port and the
// weight register (w = 2^k mod MOD) used for LSB-first accumulation.

module serial_mod_checker #(
    parameter int unsigned MOD   = 3,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned RW   = $clog2(MOD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             frame_start,
`ifdef SMC_LSB_MODE_EN
    input  logic             lsb_first,
`endif
    output logic             out_valid,
    output logic [RW-1:0]    remainder,
    output logic             divisible,
    output logic [CNT_W-1:0] bit_count,
    output logic             busy
);

    if ((MOD < 2) || (MOD > 255)) begin : g_mod_range_err
        $error("serial_mod_checker: MOD must be in the range 2..255");
    end

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StAcc  = 1'b1;

    localparam logic [RW:0]      ModW   = MOD[RW:0];
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    // Operand is always < 2*MOD, so one conditional subtract brings it into range.
    function automatic logic [RW-1:0] mod_reduce(input logic [RW:0] x);
        logic [RW:0] y;
        y = (x >= ModW) ? (x - ModW) : x;
        return y[RW-1:0];
    endfunction

    logic [0:0]       state_q, state_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;

    logic             first_bit;
    logic [RW-1:0]    rem_base;
    logic [RW-1:0]    msb_rem;
    logic [RW-1:0]    new_rem;
    logic [CNT_W-1:0] cnt_inc;

    // A bit opening a frame sees a previous remainder of 0.
    assign first_bit = (state_q == StIdle) || frame_start;
    assign rem_base  = first_bit ? '0 : rem_q;

    // MSB-first: r' = 2r + b, reduced.
    assign msb_rem = mod_reduce({rem_base, in_bit});

    assign cnt_inc = first_bit          ? CntOne :
                     (cnt_q == '1)      ? cnt_q  :
                                          cnt_q + CntOne;

`ifdef SMC_LSB_MODE_EN
    localparam logic [RW-1:0] WeightOne = RW'(1);

    logic [RW-1:0] weight_q, weight_d;
    logic [RW-1:0] w_cur;
    logic [RW-1:0] lsb_rem;
    logic [RW-1:0] w_next;

    // Weight of the current bit is 2^k mod MOD; the first bit of a frame has weight 1.
    assign w_cur   = first_bit ? WeightOne : weight_q;
    assign lsb_rem = mod_reduce({1'b0, rem_base} + (in_bit ? {1'b0, w_cur} : '0));
    assign w_next  = mod_reduce({w_cur, 1'b0});
    assign new_rem = lsb_first ? lsb_rem : msb_rem;

    always_comb begin
        weight_d = weight_q;
        if (in_valid) begin
            weight_d = w_next;
        end else if (frame_start && (state_q == StAcc)) begin
            weight_d = WeightOne;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            weight_q <= WeightOne;
        end else begin
            weight_q <= weight_d;
        end
    end
`else
    assign new_rem = msb_rem;
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (in_valid) begin
            state_d = StAcc;
            rem_d   = new_rem;
            cnt_d   = cnt_inc;
            valid_d = 1'b1;
        end else if (frame_start && (state_q == StAcc)) begin
            // Close the frame without a new bit.
            state_d = StIdle;
            rem_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign remainder = rem_q;
    assign divisible = (rem_q == '0);
    assign bit_count = cnt_q;
    assign busy      = (state_q == StAcc);

endmodule

// File: tb/tb_serial_mod_checker.sv
// Bench for serial_mod_checker: five instances (MOD 3/5/7/3 with 4-bit counter/13)
// share one stimulus stream; each is compared against an arithmetic model of the
// frame value mod MOD, plus directed constant checks for the listed scenarios.

module tb_serial_mod_checker;

    localparam int N = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic frame_start = 1'b0;
    logic lsb_first = 1'b0;

    logic [1:0]  r0, r3;
    logic [2:0]  r1, r2;
    logic [3:0]  r4;
    logic [15:0] c0, c1, c2, c4;
    logic [3:0]  c3;
    logic [N-1:0] ov, dv, bz;

    logic [7:0]  rem_a [N];
    logic [15:0] cnt_a [N];

    assign rem_a[0] = 8'(r0);
    assign rem_a[1] = 8'(r1);
    assign rem_a[2] = 8'(r2);
    assign rem_a[3] = 8'(r3);
    assign rem_a[4] = 8'(r4);
    assign cnt_a[0] = c0;
    assign cnt_a[1] = c1;
    assign cnt_a[2] = c2;
    assign cnt_a[3] = 16'(c3);
    assign cnt_a[4] = c4;

    serial_mod_checker #(.MOD(3)) u_m3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .frame_start(frame_start),
`ifdef SMC_LSB_MODE_EN
        .lsb_first(lsb_first),
`endif
        .out_valid(ov[0]), .remainder(r0), .divisible(dv[0]), .bit_count(c0), .busy(bz[0])
    );
    serial_mod_checker #(.MOD(5)) u_m5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .frame_start(frame_start),
`ifdef SMC_LSB_MODE_EN
        .lsb_first(lsb_first),
`endif
        .out_valid(ov[1]), .remainder(r1), .divisible(dv[1]), .bit_count(c1), .busy(bz[1])
    );
    serial_mod_checker #(.MOD(7)) u_m7 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .frame_start(frame_start),
`ifdef SMC_LSB_MODE_EN
        .lsb_first(lsb_first),
`endif
        .out_valid(ov[2]), .remainder(r2), .divisible(dv[2]), .bit_count(c2), .busy(bz[2])
    );
    serial_mod_checker #(.MOD(3), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .frame_start(frame_start),
`ifdef SMC_LSB_MODE_EN
        .lsb_first(lsb_first),
`endif
        .out_valid(ov[3]), .remainder(r3), .divisible(dv[3]), .bit_count(c3), .busy(bz[3])
    );
    serial_mod_checker #(.MOD(13)) u_m13 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .frame_start(frame_start),
`ifdef SMC_LSB_MODE_EN
        .lsb_first(lsb_first),
`endif
        .out_valid(ov[4]), .remainder(r4), .divisible(dv[4]), .bit_count(c4), .busy(bz[4])
    );

    int n_assert = 0;
    int n_fail = 0;

    // Reference model: frame value mod MOD, built with plain arithmetic.
    int m_rem [N];
    int m_cnt [N];
    bit m_busy = 1'b0;
    bit m_ov = 1'b0;
    int m_k = 0;

    function automatic int mod_of(int i);
        case (i)
            0: return 3;
            1: return 5;
            2: return 7;
            3: return 3;
            default: return 13;
        endcase
    endfunction

    function automatic int cnt_max(int i);
        return (i == 3) ? 15 : 65535;
    endfunction

    function automatic int pow2mod(int k, int m);
        int p = 1;
        for (int j = 0; j < k; j++) p = (p * 2) % m;
        return p;
    endfunction

    task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0d expected %0d", tag, i, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_rem[i] = 0;
            m_cnt[i] = 0;
        end
        m_k = 0;
    endtask

    task automatic model_update(bit r, bit v, bit b, bit fs, bit lsb);
        if (r) begin
            model_clear();
            m_busy = 1'b0;
            m_ov = 1'b0;
        end else if (v) begin
            if (!m_busy || fs) model_clear();
            for (int i = 0; i < N; i++) begin
                if (lsb) m_rem[i] = (m_rem[i] + (b ? pow2mod(m_k, mod_of(i)) : 0)) % mod_of(i);
                else     m_rem[i] = (2 * m_rem[i] + int'(b)) % mod_of(i);
                if (m_cnt[i] < cnt_max(i)) m_cnt[i]++;
            end
            m_k++;
            m_busy = 1'b1;
            m_ov = 1'b1;
        end else begin
            m_ov = 1'b0;
            if (fs && m_busy) begin
                model_clear();
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk("rem", i, 32'(rem_a[i]), 32'(m_rem[i]));
            chk("div", i, 32'(dv[i]), 32'(m_rem[i] == 0));
            chk("cnt", i, 32'(cnt_a[i]), 32'(m_cnt[i]));
            chk("out_valid", i, 32'(ov[i]), 32'(m_ov));
            chk("busy", i, 32'(bz[i]), 32'(m_busy));
        end
    endtask

    task automatic step(bit r, bit v, bit b, bit fs);
        rst = r;
        in_valid = v;
        in_bit = b;
        frame_start = fs;
        @(posedge clk);
        model_update(r, v, b, fs, lsb_first);
        #1;
        check_all();
    endtask

    initial begin
        int exp_b [4];
        int bits_b [4];
        int exp_c [3];
        bit r, v, b, fs;

        exp_b  = '{1, 2, 0, 0};
        bits_b = '{1, 0, 1, 0};
        exp_c  = '{1, 3, 0};
        model_clear();

        // Reset values
        step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        chk("rst_rem", 0, 32'(r0), 0);
        chk("rst_div", 0, 32'(dv[0]), 1);
        chk("rst_ov", 0, 32'(ov[0]), 0);
        chk("rst_cnt", 0, 32'(c0), 0);
        chk("rst_busy", 0, 32'(bz[0]), 0);

        // Divide-by-3 instance, value 6 MSB-first
        step(0, 1, 1, 1);
        chk("A_rem1", 0, 32'(r0), 1);
        chk("A_div1", 0, 32'(dv[0]), 0);
        chk("A_cnt1", 0, 32'(c0), 1);
        chk("A_ov1", 0, 32'(ov[0]), 1);
        step(0, 1, 1, 0);
        chk("A_rem2", 0, 32'(r0), 0);
        chk("A_cnt2", 0, 32'(c0), 2);
        step(0, 1, 0, 0);
        chk("A_rem3", 0, 32'(r0), 0);
        chk("A_div3", 0, 32'(dv[0]), 1);
        chk("A_cnt3", 0, 32'(c0), 3);
        step(0, 0, 0, 0);
        chk("A_ov_idle", 0, 32'(ov[0]), 0);

        // Divide-by-5 instance, value 10 with 2-cycle gaps
        for (int j = 0; j < 4; j++) begin
            step(0, 1, bits_b[j][0], j == 0);
            chk("B_rem", 1, 32'(r1), 32'(exp_b[j]));
            chk("B_ov", 1, 32'(ov[1]), 1);
            for (int g = 0; g < 2; g++) begin
                step(0, 0, 1, 0);
                chk("B_gap_rem", 1, 32'(r1), 32'(exp_b[j]));
                chk("B_gap_ov", 1, 32'(ov[1]), 0);
            end
        end

        // Divide-by-7 instance, nine ones
        for (int j = 0; j < 9; j++) begin
            step(0, 1, 1, j == 0);
            chk("C_rem", 2, 32'(r2), 32'(exp_c[j % 3]));
            chk("C_div", 2, 32'(dv[2]), 32'((j % 3) == 2));
        end

        // Divide-by-3 instance: restart mid-frame, then close the frame
        step(0, 1, 1, 1);
        chk("D_rem1", 0, 32'(r0), 1);
        step(0, 1, 0, 0);
        chk("D_rem2", 0, 32'(r0), 2);
        chk("D_cnt2", 0, 32'(c0), 2);
        step(0, 1, 1, 1);
        chk("D_rem3", 0, 32'(r0), 1);
        chk("D_cnt3", 0, 32'(c0), 1);
        step(0, 0, 0, 1);
        chk("D_idle_rem", 0, 32'(r0), 0);
        chk("D_idle_div", 0, 32'(dv[0]), 1);
        chk("D_idle_busy", 0, 32'(bz[0]), 0);
        chk("D_idle_cnt", 0, 32'(c0), 0);

        // CNT_W=4 saturation, then reset mid-frame
        for (int j = 0; j < 20; j++) begin
            step(0, 1, 0, j == 0);
            chk("E_cnt", 3, 32'(c3), 32'((j + 1 > 15) ? 15 : j + 1));
            chk("E_rem", 3, 32'(r3), 0);
        end
        step(1, 1, 1, 0);
        chk("E_rst_cnt", 3, 32'(c3), 0);
        chk("E_rst_rem", 3, 32'(r3), 0);
        chk("E_rst_ov", 3, 32'(ov[3]), 0);
        chk("E_rst_busy", 3, 32'(bz[3]), 0);
        chk("E_rst_div", 3, 32'(dv[3]), 1);

`ifdef SMC_LSB_MODE_EN
        // Divide-by-3 instance LSB-first, value 6
        lsb_first = 1'b1;
        step(0, 1, 0, 1);
        chk("L_rem1", 0, 32'(r0), 0);
        chk("L_div1", 0, 32'(dv[0]), 1);
        step(0, 1, 1, 0);
        chk("L_rem2", 0, 32'(r0), 2);
        chk("L_div2", 0, 32'(dv[0]), 0);
        step(0, 1, 1, 0);
        chk("L_rem3", 0, 32'(r0), 0);
        chk("L_div3", 0, 32'(dv[0]), 1);
        step(0, 0, 0, 1);
        lsb_first = 1'b0;
`endif

        // Random traffic against the model
        for (int t = 0; t < 600; t++) begin
            r  = ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 3) != 0);
            b  = 1'($urandom);
            fs = ($urandom_range(0, 11) == 0);
`ifdef SMC_LSB_MODE_EN
            // Mode only changes where a new frame begins.
            if (!m_busy || (fs && v)) lsb_first = 1'($urandom);
`endif
            step(r, v, b, fs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
